// File: rtl/button_conditioner.sv
// button_conditioner: per-button sync, debounce and press/rel/rpt pulses; ports clk, rst (sync active-low), btn raw pads, level, press, rel (release pulse), rpt (auto-repeat pulse)
module button_conditioner #(
  parameter int NUM_BTN = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] rel,
  output logic [NUM_BTN-1:0] rpt
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RD_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam bit RPT_EN = REPEAT_DELAY != 0;
  logic [NUM_BTN-1:0] s1, s2;
  always_ff @(posedge clk)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [CNT_W-1:0] dcnt, rcnt;
    logic lv, pr, rl, rp, commit;
    assign commit = s2[i] != lv && dcnt == DB_LAST;
    always_ff @(posedge clk)
      if (!rst) begin
        dcnt <= '0;
        rcnt <= '0;
        lv <= 1'b0;
        pr <= 1'b0;
        rl <= 1'b0;
        rp <= 1'b0;
      end else begin
        dcnt <= (s2[i] == lv || commit) ? '0 : dcnt + 1'b1;
        lv <= commit ? s2[i] : lv;
        pr <= commit && s2[i];
        rl <= commit && !s2[i];
        rp <= RPT_EN && lv && !commit && rcnt == RD_LAST;
        rcnt <= (!RPT_EN || !lv || commit) ? '0 : rcnt == RD_LAST ? RD_RELOAD : rcnt + 1'b1;
      end
    assign level[i] = lv;
    assign press[i] = pr;
    assign rel[i] = rl;
    assign rpt[i] = rp;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus checked against a cycle-indexed reference model
module tb_button_conditioner;
  localparam int NB = 5, DB = 4, RD = 10, RP = 3;
  logic clk = 1'b0, rst = 1'b0;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] level, press, rel, rpt;
  int checks = 0, failures = 0, n = 0;
  logic [NB-1:0] bsamp[$];
  logic [NB-1:0] mlvl, mpress, mrel, mrpt;
  int last_commit[NB], press_edge[NB];
  button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .level(level), .press(press), .rel(rel), .rpt(rpt)
  );
  always #5 clk = ~clk;
  // synchronised sample seen by the debouncer at edge k is the pad value captured two edges earlier
  function automatic logic used(input int k, input int ch);
    return k >= 2 ? bsamp[k-2][ch] : 1'b0;
  endfunction
  task automatic model_reset();
    bsamp.delete();
    n = 0;
    mlvl = '0; mpress = '0; mrel = '0; mrpt = '0;
    for (int c = 0; c < NB; c++) begin
      last_commit[c] = -1;
      press_edge[c] = 0;
    end
  endtask
  // a new level is accepted once DB consecutive samples since the last change all disagree with it;
  // repeats fire RD edges after the press and every RP edges thereafter while held
  task automatic model_edge();
    bsamp.push_back(btn);
    mpress = '0; mrel = '0; mrpt = '0;
    for (int c = 0; c < NB; c++) begin
      bit commit;
      int age;
      commit = (n - last_commit[c]) >= DB;
      for (int k = n - DB + 1; k <= n; k++)
        if (used(k, c) == mlvl[c]) commit = 0;
      age = n - press_edge[c];
      mrpt[c] = mlvl[c] && !commit && age >= RD && ((age - RD) % RP) == 0;
      if (commit) begin
        mlvl[c] = ~mlvl[c];
        last_commit[c] = n;
        if (mlvl[c]) begin
          press_edge[c] = n;
          mpress[c] = 1'b1;
        end else mrel[c] = 1'b1;
      end
    end
    n++;
  endtask
  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at n=%0d", tag, obs, exp, n);
    end
  endtask
  task automatic step(input logic [NB-1:0] v);
    @(negedge clk);
    btn = v;
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    #1;
    check("model_level", level, mlvl);
    check("model_press", press, mpress);
    check("model_release", rel, mrel);
    check("model_repeat", rpt, mrpt);
  endtask
  task automatic hold(input logic [NB-1:0] v, input int cnt);
    for (int k = 0; k < cnt; k++) step(v);
  endtask
  initial begin
    model_reset();
    rst = 1'b0;
    hold('0, 2);
    rst = 1'b1;
    hold('0, 3);
    // clean press on channel 0
    hold(5'b00001, 5);
    check("clean_no_early_press", press, 5'b00000);
    step(5'b00001);
    check("clean_press", press, 5'b00001);
    check("clean_level", level, 5'b00001);
    step(5'b00001);
    check("press_one_cycle", press, 5'b00000);
    // release on channel 0
    hold(5'b00000, 5);
    check("release_not_early", rel, 5'b00000);
    step(5'b00000);
    check("release_pulse", rel, 5'b00001);
    check("release_level", level, 5'b00000);
    // glitch rejection on channel 1
    hold(5'b00010, 3);
    hold(5'b00000, 8);
    check("glitch_level", level, 5'b00000);
    hold(5'b00010, 3);
    step(5'b00000);
    hold(5'b00010, 3);
    step(5'b00010);
    step(5'b00010);
    check("glitch2_not_early", level, 5'b00000);
    step(5'b00010);
    check("glitch2_press", press, 5'b00010);
    hold(5'b00000, 8);
    // auto-repeat on channel 2, release commit on a repeat edge
    hold(5'b00100, 5);
    step(5'b00100);
    check("repeat_press", press, 5'b00100);
    for (int k = 1; k <= 19; k++) begin
      step(k < 14 ? 5'b00100 : 5'b00000);
      if (k == 10 || k == 13 || k == 16) check("repeat_pulse", rpt, 5'b00100);
      if (k == 11) check("repeat_gap", rpt, 5'b00000);
      if (k == 19) begin
        check("release_wins_rel", rel, 5'b00100);
        check("release_wins_rpt", rpt, 5'b00000);
      end
    end
    hold(5'b00000, 12);
    // reset while channel 3 is held and accepted
    hold(5'b01000, 8);
    check("pre_reset_level", level, 5'b01000);
    rst = 1'b0;
    step(5'b01000);
    rst = 1'b1;
    check("reset_level", level, 5'b00000);
    check("reset_release", rel, 5'b00000);
    check("reset_press", press, 5'b00000);
    hold(5'b01000, 5);
    check("post_reset_no_early", press, 5'b00000);
    step(5'b01000);
    check("post_reset_press", press, 5'b01000);
    hold(5'b00000, 8);
    // channels 0 and 4 together, channel 4 bouncing once
    hold(5'b10001, 2);
    step(5'b00001);
    hold(5'b10001, 2);
    step(5'b10001);
    check("multi_press0", press, 5'b00001);
    hold(5'b10001, 2);
    step(5'b10001);
    check("multi_press4", press, 5'b10000);
    hold(5'b00000, 8);
    // random toggling with occasional resets
    for (int k = 0; k < 1500; k++) begin
      logic [NB-1:0] flip;
      for (int c = 0; c < NB; c++) flip[c] = $urandom_range(0, 5) == 0;
      rst = $urandom_range(0, 199) != 0;
      step(btn ^ flip);
      rst = 1'b1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
